// File: rtl/proj_minhash_sketch.sv
// MinHash sketch: evaluates NUM_HASH affine hashes on each accepted k-mer, tracks per-hash minima
// over a sequence and hands the finished signature downstream through a valid/ready handshake.
module proj_minhash_sketch #(
    parameter int KMER_BITS  = 8,
    parameter int HASH_BITS  = 16,
    parameter int NUM_HASH   = 4,
    parameter int SEED_A     = 40503,
    parameter int SEED_B     = 1,
    parameter int COUNT_BITS = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [KMER_BITS-1:0]          in_kmer,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    input  logic                          start_over,
    output logic [NUM_HASH*HASH_BITS-1:0] sig,
    output logic                          sig_valid,
    input  logic                          sig_ready,
    output logic [COUNT_BITS-1:0]         kmer_count
);

    localparam int PROD_BITS = HASH_BITS + KMER_BITS;
    localparam logic [HASH_BITS-1:0]  HASH_ONES = '1;
    localparam logic [COUNT_BITS-1:0] COUNT_MAX = '1;

    typedef enum logic {ACCUM, OUTPUT} state_t;

    state_t                state_q;
    logic                  in_ready_q;
    logic                  sig_valid_q;
    logic [COUNT_BITS-1:0] count_q;
    logic [COUNT_BITS-1:0] count_d;
    logic [HASH_BITS-1:0]  hash_val [NUM_HASH];
    logic [HASH_BITS-1:0]  min_q    [NUM_HASH];
    logic [HASH_BITS-1:0]  min_d    [NUM_HASH];

    generate
        for (genvar gi = 0; gi < NUM_HASH; gi++) begin : g_hash
            localparam logic [HASH_BITS-1:0] A_I = HASH_BITS'(SEED_A + 2 * gi);
            localparam logic [HASH_BITS-1:0] B_I = HASH_BITS'(SEED_B * (gi + 1));
            logic [PROD_BITS-1:0] prod;

            // Full-width product, then the sum is truncated: the hash is taken mod 2^HASH_BITS.
            assign prod         = PROD_BITS'(A_I) * PROD_BITS'(in_kmer);
            assign hash_val[gi] = HASH_BITS'(prod + PROD_BITS'(B_I));
            assign min_d[gi]    = (hash_val[gi] < min_q[gi]) ? hash_val[gi] : min_q[gi];
            assign sig[gi*HASH_BITS +: HASH_BITS] = min_q[gi];
        end
    endgenerate

    assign count_d = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_BITS'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            in_ready_q  <= 1'b1;
            sig_valid_q <= 1'b0;
            count_q     <= '0;
            for (int i = 0; i < NUM_HASH; i++) min_q[i] <= HASH_ONES;
        end else if (start_over) begin
            // Abandons the sequence even if an accept or a handshake coincides with it.
            state_q     <= ACCUM;
            in_ready_q  <= 1'b1;
            sig_valid_q <= 1'b0;
            count_q     <= '0;
            for (int i = 0; i < NUM_HASH; i++) min_q[i] <= HASH_ONES;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        count_q <= count_d;
                        for (int i = 0; i < NUM_HASH; i++) min_q[i] <= min_d[i];
                        if (in_last) begin
                            state_q     <= OUTPUT;
                            in_ready_q  <= 1'b0;
                            sig_valid_q <= 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (sig_ready) begin
                        state_q     <= ACCUM;
                        in_ready_q  <= 1'b1;
                        sig_valid_q <= 1'b0;
                        count_q     <= '0;
                        for (int i = 0; i < NUM_HASH; i++) min_q[i] <= HASH_ONES;
                    end
                end
                default: begin
                    state_q     <= ACCUM;
                    in_ready_q  <= 1'b1;
                    sig_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign sig_valid  = sig_valid_q;
    assign kmer_count = count_q;

endmodule

// File: tb/tb_proj_minhash_sketch.sv
// Bench for proj_minhash_sketch: three parameterisations share one stimulus stream; signatures are
// checked against a scoreboard of hand-derived expectations.
module tb_proj_minhash_sketch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_kmer = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        start_over = 1'b0;
    logic        sig_ready = 1'b0;

    logic        rdy_a, rdy_b, rdy_c;
    logic        sv_a, sv_b, sv_c;
    logic [31:0] sig_a;
    logic [15:0] sig_b;
    logic [63:0] sig_c;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    always #5 clk = ~clk;

    proj_minhash_sketch #(.KMER_BITS(8), .HASH_BITS(16), .NUM_HASH(2), .SEED_A(3), .SEED_B(7),
                          .COUNT_BITS(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_kmer(in_kmer), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy_a), .start_over(start_over), .sig(sig_a), .sig_valid(sv_a),
        .sig_ready(sig_ready), .kmer_count(cnt_a));

    proj_minhash_sketch #(.KMER_BITS(8), .HASH_BITS(8), .NUM_HASH(2), .SEED_A(3), .SEED_B(7),
                          .COUNT_BITS(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_kmer(in_kmer), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy_b), .start_over(start_over), .sig(sig_b), .sig_valid(sv_b),
        .sig_ready(sig_ready), .kmer_count(cnt_b));

    proj_minhash_sketch #(.KMER_BITS(8), .HASH_BITS(16), .NUM_HASH(4), .SEED_A(40503), .SEED_B(1),
                          .COUNT_BITS(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_kmer(in_kmer), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy_c), .start_over(start_over), .sig(sig_c), .sig_valid(sv_c),
        .sig_ready(sig_ready), .kmer_count(cnt_c));

    typedef struct {
        logic [31:0] sig_a;
        logic [15:0] sig_b;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        logic [7:0]  kmer;
        logic [15:0] a0, a1;
        logic [7:0]  b0, b1;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Called at a falling edge; the k-mer is presented across the next rising edge.
    task automatic drive_kmer(input logic [7:0] k, input logic last);
        in_kmer  = k;
        in_valid = 1'b1;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] sa, input logic [15:0] sb, input logic [15:0] c);
        exp_t e;
        e.sig_a = sa;
        e.sig_b = sb;
        e.cnt   = c;
        sb_q.push_back(e);
    endtask

    task automatic collect();
        int   n = 0;
        exp_t e;
        while (!sv_a && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!sv_a) begin
            checks++;
            failures++;
            $display("FAIL sig_timeout actual=sig_valid_low required=sig_valid_high");
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            return;
        end
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_sig actual=sig_valid_high required=no_signature");
            return;
        end
        e = sb_q.pop_front();
        check("sig_a", sig_a, e.sig_a);
        check("sig_b", sig_b, e.sig_b);
        check("count_at_sig", cnt_a, e.cnt);
        check("in_ready_in_output", rdy_a, 0);
        check("sig_valid_b", sv_b, 1);
        $display("txn sig_a=%h sig_b=%h kmer_count=%0d", sig_a, sig_b, cnt_a);
        sig_ready = 1'b1;
        @(negedge clk);
        sig_ready = 1'b0;
        check("sig_valid_after_hs", sv_a, 0);
        check("in_ready_after_hs", rdy_a, 1);
        check("count_after_hs", cnt_a, 0);
        check("mins_after_hs", sig_a, 32'hFFFF_FFFF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // kmer, A-hashes {3k+7, 5k+14}, the same taken mod 256
        vecs[0] = '{8'h00, 16'd7,   16'd14,   8'd7,   8'd14};
        vecs[1] = '{8'h10, 16'd55,  16'd94,   8'd55,  8'd94};
        vecs[2] = '{8'h02, 16'd13,  16'd24,   8'd13,  8'd24};
        vecs[3] = '{8'hFF, 16'd772, 16'd1289, 8'd4,   8'd9};
        vecs[4] = '{8'h80, 16'd391, 16'd654,  8'd135, 8'd142};
        vecs[5] = '{8'h55, 16'd262, 16'd439,  8'd6,   8'd183};

        @(negedge clk);
        check("reset_sig_valid", sv_a, 0);
        check("reset_in_ready", rdy_a, 1);
        check("reset_count", cnt_a, 0);
        check("reset_mins", sig_a, 32'hFFFF_FFFF);
        check("reset_mins_c", sig_c, 64'hFFFF_FFFF_FFFF_FFFF);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-k-mer sequences, including the 8-bit wrap-around case
        for (int i = 0; i < 6; i++) begin
            drive_kmer(vecs[i].kmer, 1'b1);
            push_exp({vecs[i].a1, vecs[i].a0}, {vecs[i].b1, vecs[i].b0}, 16'd1);
            check("sig_latency", sv_a, 1);
            collect();
        end

        // Three-k-mer sequence followed by backpressure with new k-mers offered
        drive_kmer(8'h10, 1'b0);
        check("ready_mid_seq", rdy_a, 1);
        drive_kmer(8'h02, 1'b0);
        check("ready_mid_seq", rdy_a, 1);
        drive_kmer(8'h20, 1'b1);
        push_exp({16'd24, 16'd13}, {8'd24, 8'd13}, 16'd3);
        check("sig_latency_multi", sv_a, 1);
        for (int j = 0; j < 5; j++) begin
            in_kmer  = 8'(j);
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_sig_valid", sv_a, 1);
            check("bp_sig_stable", sig_a, {16'd24, 16'd13});
            check("bp_count_stable", cnt_a, 3);
        end
        in_valid = 1'b0;
        collect();

        // start_over colliding with an accept drops that k-mer
        drive_kmer(8'h20, 1'b0);
        check("count_before_so", cnt_a, 1);
        in_kmer    = 8'h02;
        in_valid   = 1'b1;
        start_over = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        start_over = 1'b0;
        check("so_count", cnt_a, 0);
        check("so_mins", sig_a, 32'hFFFF_FFFF);
        check("so_ready", rdy_a, 1);
        drive_kmer(8'h10, 1'b1);
        push_exp({16'd94, 16'd55}, {8'd94, 8'd55}, 16'd1);
        collect();

        // Asynchronous reset mid-sequence, away from any clock edge
        drive_kmer(8'h02, 1'b0);
        check("count_before_rst", cnt_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_sig_valid", sv_a, 0);
        check("async_rst_count", cnt_a, 0);
        check("async_rst_ready", rdy_a, 1);
        check("async_rst_mins", sig_a, 32'hFFFF_FFFF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // in_last alone is ignored
        in_last = 1'b1;
        @(negedge clk);
        in_last = 1'b0;
        check("lone_last_sig_valid", sv_a, 0);
        check("lone_last_count", cnt_a, 0);

        // start_over in OUTPUT wins over a simultaneous handshake
        drive_kmer(8'h80, 1'b1);
        check("so_out_sig_valid_pre", sv_a, 1);
        start_over = 1'b1;
        sig_ready  = 1'b1;
        @(negedge clk);
        start_over = 1'b0;
        sig_ready  = 1'b0;
        check("so_out_sig_valid", sv_a, 0);
        check("so_out_ready", rdy_a, 1);
        check("so_out_count", cnt_a, 0);
        check("so_out_mins", sig_a, 32'hFFFF_FFFF);

        // Identical k-mers: 2-bit counter saturates, signature is the single hash
        for (int j = 0; j < 5; j++) begin
            drive_kmer(8'h03, j == 4);
            check("sat_count_c", cnt_c, (j < 3) ? j + 1 : 3);
        end
        check("sat_sig_c", sig_c, {16'd55995, 16'd55988, 16'd55981, 16'd55974});
        check("sat_sig_valid_c", sv_c, 1);
        push_exp({16'd29, 16'd16}, {8'd29, 8'd16}, 16'd5);
        collect();

        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
